// File: rtl/sr_flag_pkg.sv
// Shared command encodings and the rotating-priority search used by the flag arbiter.
// Requester counts up to MAXREQ are supported by the search helper.
package sr_flag_pkg;

  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_CLR  = 2'b01;
  localparam logic [1:0] CMD_SET  = 2'b10;
  localparam logic [1:0] CMD_INV  = 2'b11;

  localparam int MAXREQ = 16;

  // First set bit of req[0..n-1] searching upward from ptr with wrap; -1 if none.
  // Iterates downward so the closest-to-ptr candidate is assigned last and wins.
  function automatic int rr_search(input logic [MAXREQ-1:0] req, input int ptr, input int n);
    int sel;
    int idx;
    sel = -1;
    for (int i = MAXREQ - 1; i >= 0; i--) begin
      if (i < n) begin
        idx = ptr + i;
        if (idx >= n) idx = idx - n;
        if (req[idx]) sel = idx;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from rr_ptr with wrap, zero-latency grant.
// Grant is held off entirely while reset is asserted; rr_ptr moves past the winner only when advance.
module rr_arbiter
  import sr_flag_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int RIDW = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] gnt,
  output logic [RIDW-1:0] gnt_id
);

  logic [RIDW-1:0] rr_ptr;
  int              sel;

  always_comb begin
    sel    = rr_search(MAXREQ'(req), int'(rr_ptr), NREQ);
    gnt    = '0;
    gnt_id = '0;
    if (reset && sel >= 0) begin
      gnt_id      = RIDW'(sel);
      gnt[gnt_id] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + RIDW'(1);
    end
  end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Bank of set/reset flags written by NREQ requesters under round-robin arbitration.
// Flag update lands one cycle after valid&ready; requesters not granted simply wait (req_ready low).
module sr_flag_arbiter
  import sr_flag_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  localparam int IDXW = $clog2(NFLAG),
  localparam int RIDW = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*IDXW-1:0] req_idx,
  input  logic [NREQ-1:0]      req_s,
  input  logic [NREQ-1:0]      req_r,
  input  logic                 err_clr,
  output logic [NFLAG-1:0]     q,
  output logic [NFLAG-1:0]     qbar,
  output logic                 err,
  output logic [RIDW-1:0]      err_src,
  output logic [IDXW-1:0]      err_idx
);

  logic [RIDW-1:0] gid;
  logic            acc;
  logic [IDXW-1:0] cidx;
  logic [1:0]      cmd;
  logic            in_range;

  // Grant is only ever given to a valid requester, so any grant is an acceptance.
  assign acc = |req_ready;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .advance (acc),
    .gnt     (req_ready),
    .gnt_id  (gid)
  );

  always_comb begin
    cidx     = req_idx[gid*IDXW +: IDXW];
    cmd      = {req_s[gid], req_r[gid]};
    in_range = (int'(cidx) < NFLAG);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (acc && in_range) begin
      case (cmd)
        CMD_SET: q[cidx] <= 1'b1;
        CMD_CLR: q[cidx] <= 1'b0;
        default: ;
      endcase
    end
  end

  assign qbar = ~q;

  // A new invalid command takes priority over err_clr in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err     <= 1'b0;
      err_src <= '0;
      err_idx <= '0;
    end else if (acc && in_range && cmd == CMD_INV) begin
      err     <= 1'b1;
      err_src <= gid;
      err_idx <= cidx;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed self-checking bench for sr_flag_arbiter (NREQ=4, NFLAG=8).
module tb_sr_flag_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req_valid;
  logic [3:0] req_ready;
  logic [11:0] req_idx;
  logic [3:0] req_s;
  logic [3:0] req_r;
  logic       err_clr;
  logic [7:0] q;
  logic [7:0] qbar;
  logic       err;
  logic [1:0] err_src;
  logic [2:0] err_idx;

  int vectors;
  int miscompares;

  sr_flag_arbiter #(.NREQ(4), .NFLAG(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_idx   (req_idx),
    .req_s     (req_s),
    .req_r     (req_r),
    .err_clr   (err_clr),
    .q         (q),
    .qbar      (qbar),
    .err       (err),
    .err_src   (err_src),
    .err_idx   (err_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int k, input int idx, input logic s, input logic r);
    req_valid[k]        = 1'b1;
    req_idx[k*3 +: 3]   = 3'(idx);
    req_s[k]            = s;
    req_r[k]            = r;
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    req_idx   = '0;
    req_s     = '0;
    req_r     = '0;
    err_clr   = 1'b0;
  endtask

  // Single-requester command, one cycle; drives only, no checking.
  task automatic issue(input int k, input int idx, input logic s, input logic r);
    @(negedge clk);
    idle_inputs();
    set_req(k, idx, s, r);
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    req_valid = 4'hF;
    reset = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    vectors++;
    if (q !== 8'h00) begin miscompares++; $display("FAIL reset_q got=%h exp=00", q); end
    vectors++;
    if (qbar !== 8'hFF) begin miscompares++; $display("FAIL reset_qbar got=%h exp=ff", qbar); end
    vectors++;
    if ({err, err_src, err_idx} !== 6'b0) begin
      miscompares++; $display("FAIL reset_err got=%b/%0d/%0d exp=0/0/0", err, err_src, err_idx);
    end
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
  endtask

  task automatic test_single_set();
    @(negedge clk);
    idle_inputs();
    set_req(2, 5, 1'b1, 1'b0);
    #1;
    vectors++;
    if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
    vectors++;
    if (q !== 8'h00) begin miscompares++; $display("FAIL single_q_before got=%h exp=00", q); end
    @(posedge clk); #1;
    vectors++;
    if (q !== 8'h20) begin miscompares++; $display("FAIL single_q got=%h exp=20", q); end
    vectors++;
    if (qbar !== 8'hDF) begin miscompares++; $display("FAIL single_qbar got=%h exp=df", qbar); end
    idle_inputs();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt [5];
    logic [7:0] exp_q   [5];
    exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_q   = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h0F};
    do_reset(1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      idle_inputs();
      for (int k = 0; k < 4; k++) set_req(k, k, 1'b1, 1'b0);
      #1;
      vectors++;
      if (req_ready !== exp_gnt[c]) begin
        miscompares++; $display("FAIL rr_grant[%0d] got=%b exp=%b", c, req_ready, exp_gnt[c]);
      end
      @(posedge clk); #1;
      vectors++;
      if (q !== exp_q[c]) begin miscompares++; $display("FAIL rr_q[%0d] got=%h exp=%h", c, q, exp_q[c]); end
    end
    idle_inputs();
  endtask

  // Entered with rr_ptr=1 (last grant was requester 0).
  task automatic test_wrap_skip();
    logic [3:0] exp_gnt [3];
    exp_gnt = '{4'b1000, 4'b0010, 4'b1000};
    issue(2, 0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      idle_inputs();
      set_req(1, 1, 1'b0, 1'b0);
      set_req(3, 3, 1'b0, 1'b0);
      #1;
      vectors++;
      if (req_ready !== exp_gnt[c]) begin
        miscompares++; $display("FAIL wrap_grant[%0d] got=%b exp=%b", c, req_ready, exp_gnt[c]);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    vectors++;
    if (q !== 8'h0F) begin miscompares++; $display("FAIL wrap_q_hold got=%h exp=0f", q); end
  endtask

  task automatic test_clear_hold();
    for (int i = 4; i < 8; i++) issue(0, i, 1'b1, 1'b0);
    vectors++;
    if (q !== 8'hFF) begin miscompares++; $display("FAIL clr_setup_q got=%h exp=ff", q); end
    issue(0, 7, 1'b0, 1'b1);
    vectors++;
    if (q !== 8'h7F) begin miscompares++; $display("FAIL clr_q got=%h exp=7f", q); end
    issue(0, 7, 1'b0, 1'b0);
    vectors++;
    if (q !== 8'h7F) begin miscompares++; $display("FAIL hold_q got=%h exp=7f", q); end
    vectors++;
    if (qbar !== 8'h80) begin miscompares++; $display("FAIL hold_qbar got=%h exp=80", qbar); end
  endtask

  task automatic test_invalid();
    do_reset(1);
    issue(0, 0, 1'b1, 1'b0);
    @(negedge clk);
    idle_inputs();
    set_req(1, 0, 1'b1, 1'b1);
    #1;
    vectors++;
    if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL inv_ready got=%b exp=0010", req_ready); end
    @(posedge clk); #1;
    vectors++;
    if (q !== 8'h01) begin miscompares++; $display("FAIL inv_q got=%h exp=01", q); end
    vectors++;
    if ({err, err_src, err_idx} !== {1'b1, 2'd1, 3'd0}) begin
      miscompares++; $display("FAIL inv_err got=%b/%0d/%0d exp=1/1/0", err, err_src, err_idx);
    end
    @(negedge clk);
    idle_inputs();
    set_req(3, 6, 1'b1, 1'b1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({err, err_src, err_idx} !== {1'b1, 2'd3, 3'd6}) begin
      miscompares++; $display("FAIL inv_clr_race got=%b/%0d/%0d exp=1/3/6", err, err_src, err_idx);
    end
    vectors++;
    if (q !== 8'h01) begin miscompares++; $display("FAIL inv_q2 got=%h exp=01", q); end
    @(negedge clk);
    idle_inputs();
    err_clr = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({err, err_src, err_idx} !== {1'b0, 2'd3, 3'd6}) begin
      miscompares++; $display("FAIL err_clr got=%b/%0d/%0d exp=0/3/6", err, err_src, err_idx);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset(1);
    issue(0, 0, 1'b1, 1'b0);
    issue(0, 2, 1'b1, 1'b0);
    issue(0, 5, 1'b1, 1'b0);
    issue(0, 7, 1'b1, 1'b0);
    issue(0, 1, 1'b1, 1'b1);
    vectors++;
    if (q !== 8'hA5 || err !== 1'b1) begin
      miscompares++; $display("FAIL mid_setup got=%h/%b exp=a5/1", q, err);
    end
    // rr_ptr now 1; keep requesters 1 and 2 active through reset.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      idle_inputs();
      set_req(1, 3, 1'b1, 1'b0);
      set_req(2, 4, 1'b1, 1'b0);
      reset = 1'b0;
      #1;
      vectors++;
      if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL mid_ready[%0d] got=%b exp=0000", c, req_ready); end
      @(posedge clk); #1;
      vectors++;
      if (q !== 8'h00 || err !== 1'b0) begin
        miscompares++; $display("FAIL mid_state[%0d] got=%h/%b exp=00/0", c, q, err);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL mid_first_grant got=%b exp=0010", req_ready); end
    @(posedge clk); #1;
    vectors++;
    if (q !== 8'h08) begin miscompares++; $display("FAIL mid_first_q got=%h exp=08", q); end
    idle_inputs();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    idle_inputs();
    test_reset();
    test_single_set();
    test_round_robin();
    test_wrap_skip();
    test_clear_hold();
    test_invalid();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
